// File: rtl/serv_csr_irqx.sv
// serv_csr_irqx: bit-serial machine-mode CSR unit with timer and NUM_IRQ edge-qualified platform interrupts
module serv_csr_irqx #(
  parameter int NUM_IRQ   = 1,
  parameter bit WITH_MPIE = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_init,
  input  logic               i_en,
  input  logic [4:0]         i_cnt,
  input  logic               i_cnt_done,
  input  logic               i_trap,
  input  logic               i_mret,
  input  logic               i_e_op,
  input  logic               i_ebreak,
  input  logic               i_mem_op,
  input  logic               i_mem_cmd,
  input  logic               i_mstatus_en,
  input  logic               i_mie_en,
  input  logic               i_mip_en,
  input  logic               i_mcause_en,
  input  logic [1:0]         i_csr_source,
  input  logic               i_csr_d_sel,
  input  logic               i_csr_imm,
  input  logic               i_rs1,
  input  logic               i_rf_csr_out,
  input  logic               i_mtip,
  input  logic [NUM_IRQ-1:0] i_irq,
  output logic               o_new_irq,
  output logic               o_csr_in,
  output logic               o_q
);
  logic               d, csr_in, csr_out, trap_done, pend;
  logic               mie_r, mpie, mtie, pend_r, mc31;
  logic [NUM_IRQ-1:0] meie, irq_m, irq_s;
  logic [4:0]         irq_code, code, mcode, exc_code;
  logic [31:0]        mst_v, mie_v, mip_v, mc_v;
  assign d         = i_csr_d_sel ? i_csr_imm : i_rs1;
  assign trap_done = i_trap & i_cnt_done;
  assign exc_code  = i_e_op ? (i_ebreak ? 5'd3 : 5'd11) : i_mem_op ? (i_mem_cmd ? 5'd6 : 5'd4) : 5'd0;
  assign csr_out   = i_rf_csr_out | (i_mstatus_en & mst_v[i_cnt]) | (i_mie_en & mie_v[i_cnt]) |
                     (i_mip_en & mip_v[i_cnt]) | (i_mcause_en & i_en & mc_v[i_cnt]);
  assign csr_in    = i_csr_source[1] ? (i_csr_source[0] ? csr_out & ~d : csr_out | d)
                                     : (i_csr_source[0] ? d : csr_out);
  assign o_csr_in  = csr_in;
  assign o_q       = csr_out;
  always_comb begin
    mst_v                = '0;
    mst_v[3]             = mie_r;
    mst_v[7]             = WITH_MPIE & mpie;
    mie_v                = '0;
    mie_v[7]             = mtie;
    mie_v[16 +: NUM_IRQ] = meie;
    mip_v                = '0;
    mip_v[7]             = i_mtip;
    mip_v[16 +: NUM_IRQ] = irq_s;
    mc_v                 = {mc31, 26'd0, mcode};
    pend                 = mie_r & ((|(irq_s & meie)) | (i_mtip & mtie));
    code                 = 5'd7;
    for (int k = 0; k < NUM_IRQ; k++)
      code = (irq_s[k] & meie[k]) ? 5'(16 + k) : code;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      irq_m     <= '0;
      irq_s     <= '0;
      meie      <= '0;
      mtie      <= 1'b0;
      mie_r     <= 1'b0;
      mpie      <= 1'b0;
      pend_r    <= 1'b0;
      o_new_irq <= 1'b0;
      irq_code  <= '0;
      mcode     <= '0;
      mc31      <= 1'b0;
    end else begin
      irq_m <= i_irq;
      irq_s <= irq_m;
      if (i_mie_en & i_en & (i_cnt == 5'd7))
        mtie <= csr_in;
      for (int k = 0; k < NUM_IRQ; k++)
        if (i_mie_en & i_en & (i_cnt == 5'(16 + k)))
          meie[k] <= csr_in;
      if (trap_done)
        mie_r <= 1'b0;
      else if (i_mret)
        mie_r <= mpie;
      else if (i_mstatus_en & (i_cnt == 5'd3))
        mie_r <= csr_in;
      if (trap_done)
        mpie <= mie_r;
      else if (i_mret)
        mpie <= 1'b1;
      else if (WITH_MPIE & i_mstatus_en & (i_cnt == 5'd7))
        mpie <= csr_in;
      if (i_cnt_done & ~i_init) begin
        pend_r    <= pend;
        o_new_irq <= pend & ~pend_r;
        irq_code  <= code;
      end
      if (trap_done) begin
        mc31  <= o_new_irq;
        mcode <= o_new_irq ? irq_code : exc_code;
      end else if (i_mcause_en & i_en) begin
        if (i_cnt < 5'd5)
          mcode[i_cnt[2:0]] <= csr_in;
        if (i_cnt == 5'd31)
          mc31 <= csr_in;
      end
    end
  end
endmodule

// File: tb/tb_serv_csr_irqx.sv
// tb_serv_csr_irqx: directed self-checking bench for serv_csr_irqx with four platform interrupt lines
module tb_serv_csr_irqx;
  logic       i_clk = 0, i_rst = 1, i_init = 0, i_en = 0, i_cnt_done = 0;
  logic [4:0] i_cnt = 0;
  logic       i_trap = 0, i_mret = 0, i_e_op = 0, i_ebreak = 0, i_mem_op = 0, i_mem_cmd = 0;
  logic       i_mstatus_en = 0, i_mie_en = 0, i_mip_en = 0, i_mcause_en = 0;
  logic [1:0] i_csr_source = 0;
  logic       i_csr_d_sel = 0, i_csr_imm = 0, i_rs1 = 0, i_rf_csr_out = 0, i_mtip = 0;
  logic [3:0] i_irq = 0;
  logic       o_new_irq, o_csr_in, o_q;
  logic [31:0] r;
  int errors = 0, checks = 0;
  localparam logic [3:0] MST = 4'd1, MIE = 4'd2, MIP = 4'd4, MCA = 4'd8;
  localparam logic [4:0] TRAP = 5'd16, EOP = 5'd8, EBRK = 5'd4, MEMOP = 5'd2, STORE = 5'd1;
  serv_csr_irqx #(.NUM_IRQ(4), .WITH_MPIE(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_init(i_init), .i_en(i_en), .i_cnt(i_cnt), .i_cnt_done(i_cnt_done),
    .i_trap(i_trap), .i_mret(i_mret), .i_e_op(i_e_op), .i_ebreak(i_ebreak), .i_mem_op(i_mem_op),
    .i_mem_cmd(i_mem_cmd), .i_mstatus_en(i_mstatus_en), .i_mie_en(i_mie_en), .i_mip_en(i_mip_en),
    .i_mcause_en(i_mcause_en), .i_csr_source(i_csr_source), .i_csr_d_sel(i_csr_d_sel),
    .i_csr_imm(i_csr_imm), .i_rs1(i_rs1), .i_rf_csr_out(i_rf_csr_out), .i_mtip(i_mtip), .i_irq(i_irq),
    .o_new_irq(o_new_irq), .o_csr_in(o_csr_in), .o_q(o_q)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle();
    i_en = 0; i_cnt = 0; i_cnt_done = 0; {i_mcause_en, i_mip_en, i_mie_en, i_mstatus_en} = 0;
    i_csr_source = 0; i_csr_d_sel = 0; i_rs1 = 0; i_csr_imm = 0;
    {i_trap, i_e_op, i_ebreak, i_mem_op, i_mem_cmd} = 0; i_mret = 0;
  endtask
  task automatic run(input logic [1:0] src, input logic [3:0] sel, input logic [31:0] wd, input logic imm,
                     input logic [4:0] ctl, input logic mret, output logic [31:0] rd);
    for (int c = 0; c < 32; c++) begin
      @(negedge i_clk);
      i_en = 1; i_cnt = 5'(c); i_cnt_done = (c == 31);
      {i_mcause_en, i_mip_en, i_mie_en, i_mstatus_en} = sel;
      i_csr_source = src; i_csr_d_sel = imm;
      i_rs1 = imm ? ~wd[c] : wd[c];
      i_csr_imm = imm ? wd[c] : ~wd[c];
      {i_trap, i_e_op, i_ebreak, i_mem_op, i_mem_cmd} = ctl;
      i_mret = mret & (c == 31);
      #1 rd[c] = o_q;
    end
    @(negedge i_clk);
    idle();
  endtask
  task automatic rd_chk(input string tag, input logic [3:0] sel, input logic [31:0] exp);
    logic [31:0] v;
    run(2'b10, sel, 32'd0, 1'b0, 5'd0, 1'b0, v);
    check(tag, v, exp);
  endtask
  task automatic irq_chk(input string tag, input logic exp);
    check(tag, {31'd0, o_new_irq}, {31'd0, exp});
  endtask
  initial begin
    repeat (3) @(posedge i_clk);
    @(negedge i_clk) i_rst = 0;
    irq_chk("rst_new_irq", 0);
    rd_chk("rst_mstatus", MST, 0);
    rd_chk("rst_mie", MIE, 0);
    rd_chk("rst_mcause", MCA, 0);
    rd_chk("rst_mip", MIP, 0);
    run(2'b10, MIE, 32'h0001_0080, 0, 0, 0, r);
    check("csrrs_mie_old", r, 0);
    rd_chk("mie_set", MIE, 32'h0001_0080);
    run(2'b11, MIE, 32'h0000_0080, 0, 0, 0, r);
    rd_chk("mie_clr", MIE, 32'h0001_0000);
    i_mtip = 1; i_irq = 4'b0101;
    repeat (3) @(posedge i_clk);
    run(2'b01, MIP, 32'hFFFF_FFFF, 0, 0, 0, r);
    check("mip_wr_old", r, 32'h0005_0080);
    rd_chk("mip_ro", MIP, 32'h0005_0080);
    irq_chk("no_irq_mie0", 0);
    i_mtip = 0; i_irq = 0;
    repeat (3) @(posedge i_clk);
    run(2'b01, MIE, 32'h000F_0000, 0, 0, 0, r);
    check("csrrw_mie_old", r, 32'h0001_0000);
    run(2'b10, MST, 32'h0000_0008, 1, 0, 0, r);
    rd_chk("mstatus_imm", MST, 32'h0000_0008);
    i_irq = 4'b0101;
    repeat (3) @(posedge i_clk);
    rd_chk("mstatus_pre", MST, 32'h0000_0008);
    irq_chk("irq_pulse", 1);
    run(2'b00, 4'd0, 0, 0, TRAP, 0, r);
    irq_chk("irq_after_trap", 0);
    rd_chk("mcause_irq2", MCA, 32'h8000_0012);
    rd_chk("mstatus_trap", MST, 32'h0000_0080);
    i_irq = 0;
    repeat (3) @(posedge i_clk);
    run(2'b00, 4'd0, 0, 0, 0, 1, r);
    rd_chk("mstatus_mret", MST, 32'h0000_0088);
    run(2'b01, MIE, 32'h000E_0080, 0, 0, 0, r);
    i_irq = 4'b0001; i_mtip = 1;
    repeat (3) @(posedge i_clk);
    rd_chk("mip_timer", MIP, 32'h0001_0080);
    irq_chk("timer_pulse", 1);
    run(2'b00, 4'd0, 0, 0, TRAP, 0, r);
    rd_chk("mcause_timer", MCA, 32'h8000_0007);
    rd_chk("mstatus_trap2", MST, 32'h0000_0080);
    i_irq = 0; i_mtip = 0;
    repeat (3) @(posedge i_clk);
    run(2'b00, 4'd0, 0, 0, 0, 1, r);
    rd_chk("mstatus_mret2", MST, 32'h0000_0088);
    run(2'b00, 4'd0, 0, 0, TRAP | EOP | EBRK, 0, r);
    rd_chk("mcause_ebreak", MCA, 32'd3);
    run(2'b00, 4'd0, 0, 0, TRAP | EOP, 0, r);
    rd_chk("mcause_ecall", MCA, 32'd11);
    run(2'b00, 4'd0, 0, 0, TRAP | MEMOP | STORE, 0, r);
    rd_chk("mcause_store", MCA, 32'd6);
    run(2'b00, 4'd0, 0, 0, TRAP | MEMOP, 0, r);
    rd_chk("mcause_load", MCA, 32'd4);
    run(2'b01, MCA, 32'h8000_001F, 0, 0, 0, r);
    rd_chk("mcause_wr", MCA, 32'h8000_001F);
    run(2'b01, MCA, 32'h0000_FFE0, 0, 0, 0, r);
    check("mcause_wr_old", r, 32'h8000_001F);
    rd_chk("mcause_wr0", MCA, 0);
    run(2'b01, MCA, 32'hFFFF_FFFF, 0, TRAP | EOP | EBRK, 0, r);
    rd_chk("mcause_trap_wins", MCA, 32'd3);
    run(2'b10, MST, 32'h0000_0008, 0, 0, 0, r);
    run(2'b01, MIE, 32'h0001_0000, 0, 0, 0, r);
    i_irq = 4'b0001;
    repeat (3) @(posedge i_clk);
    rd_chk("mip_irq0", MIP, 32'h0001_0000);
    irq_chk("edge_pulse1", 1);
    repeat (5) @(posedge i_clk);
    #1 irq_chk("edge_hold", 1);
    rd_chk("mstatus_edge", MST, 32'h0000_0008);
    irq_chk("edge_level1", 0);
    rd_chk("mie_edge", MIE, 32'h0001_0000);
    irq_chk("edge_level2", 0);
    i_irq = 0;
    repeat (2) @(posedge i_clk);
    rd_chk("mip_drop", MIP, 0);
    irq_chk("edge_low", 0);
    i_irq = 4'b0001;
    repeat (3) @(posedge i_clk);
    rd_chk("mip_rise", MIP, 32'h0001_0000);
    irq_chk("edge_pulse2", 1);
    for (int c = 0; c <= 12; c++) begin
      @(negedge i_clk);
      i_en = 1; i_cnt = 5'(c); i_mstatus_en = 1; i_csr_source = 2'b01; i_rs1 = (c == 3);
      i_rst = (c == 12);
    end
    @(posedge i_clk);
    #1 irq_chk("rst_mid_irq", 0);
    @(negedge i_clk);
    i_rst = 0; i_irq = 0;
    idle();
    rd_chk("rst_mid_mstatus", MST, 0);
    rd_chk("rst_mid_mcause", MCA, 0);
    irq_chk("rst_mid_irq2", 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
